// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : md_ctrl
// Purpose : E-stage multiply/divide sequencer owning HI/LO, with a
//           down-counter latency model and a pipeline stall request.
// Rev     : 1.0  initial release
// ============================================================================
module md_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        respon,
  input  logic        E_valid,
  input  logic        startE,
  input  logic [1:0]  MDopE,
  input  logic        MDsignE,
  input  logic        immWriteE,
  input  logic        HIWriteE,
  input  logic        HLToRegE,
  input  logic        HIReadE,
  input  logic [31:0] rd1E,
  input  logic [31:0] rd2E,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hlout,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [4:0] C_MUL_N = 5'(MUL_CYCLES);
  localparam logic [4:0] C_DIV_N = 5'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        go, mt;
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;
  logic [31:0] div_q, div_r;

  assign busy     = (state_q == RUN);
  assign go       = E_valid & startE & ~MDopE[1] & ~respon & ~busy;
  assign mt       = E_valid & immWriteE & ~startE & ~respon & ~busy;
  assign md_stall = E_valid & busy & (startE | immWriteE | HLToRegE);
  assign hlout    = HIReadE ? hi_q : lo_q;
  assign HI       = hi_q;
  assign LO       = lo_q;

  // One 64x64 multiplier serves both signednesses: the low 64 bits of the
  // product of sign- or zero-extended operands are exact in either case.
  always_comb begin
    mul_a = {{32{MDsignE & rd1E[31]}}, rd1E};
    mul_b = {{32{MDsignE & rd2E[31]}}, rd2E};
    prod  = mul_a * mul_b;
  end

  // Signed divide via magnitudes; the 0x8000_0000 / -1 case falls out
  // naturally because the magnitude 0x8000_0000 is representable unsigned.
  always_comb begin
    a_neg = MDsignE & rd1E[31];
    b_neg = MDsignE & rd2E[31];
    a_mag = a_neg ? (~rd1E + 32'd1) : rd1E;
    b_mag = b_neg ? (~rd2E + 32'd1) : rd2E;
    q_mag = '0;
    r_mag = '0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    div_q = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    div_r = a_neg ? (~r_mag + 32'd1) : r_mag;
    if (rd2E == 32'd0) begin
      div_q = 32'hFFFF_FFFF;
      div_r = rd1E;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          if (MDopE[0]) begin
            res_hi_d = div_r;
            res_lo_d = div_q;
            cnt_d    = C_DIV_N;
          end else begin
            res_hi_d = prod[63:32];
            res_lo_d = prod[31:0];
            cnt_d    = C_MUL_N;
          end
          state_d = RUN;
        end else if (mt) begin
          if (HIWriteE) hi_d = rd1E;
          else          lo_d = rd1E;
        end
      end
      RUN: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          hi_d    = res_hi_q;
          lo_d    = res_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule
`default_nettype wire
